// File: rtl/barrier_field_if.sv
// ----------------------------------------------------------------------------
// barrier_field_if
//   Signal bundle between the game control side (tick divider, cart
//   controller, playfield wipe) and the scrolling barrier playfield.
//
//   Signals
//     clear     single-cycle playfield wipe pulse
//     tick      one-cycle rate enable from the clock divider
//     run       game active; low freezes scrolling
//     cart_col  one-hot cart position in the bottom row (all-zero = no cart)
//     field     barrier map, bit r*COLS+c = row r, column c
//     crash     sticky collision flag
//     score     barrier rows dodged, saturating at 255
//
//   Modports
//     master    game control / bench side: drives the controls, reads the map
//     slave     playfield side: reads the controls, drives the map
// ----------------------------------------------------------------------------
interface barrier_field_if #(
    parameter int ROWS = 8,
    parameter int COLS = 8
);
    logic                 clear;
    logic                 tick;
    logic                 run;
    logic [COLS-1:0]      cart_col;
    logic [ROWS*COLS-1:0] field;
    logic                 crash;
    logic [7:0]           score;

    modport master (
        output clear,
        output tick,
        output run,
        output cart_col,
        input  field,
        input  crash,
        input  score
    );

    modport slave (
        input  clear,
        input  tick,
        input  run,
        input  cart_col,
        output field,
        output crash,
        output score
    );
endinterface

// File: rtl/barrier_field.sv
// ----------------------------------------------------------------------------
// barrier_field
//   Scrolling obstacle playfield for the cart game. A ROWS x COLS barrier map
//   scrolls one row toward the cart row every SPEED_DIV qualifying ticks.
//   New barriers are spawned in row 0 from a free-running 16-bit LFSR, with
//   barrier rows alternating with empty rows. The cart row (ROWS-1) is
//   compared against the cart position every cycle; any overlap latches a
//   sticky crash that freezes the playfield until reset. A one-cycle clear
//   pulse wipes the map and restarts the scroll phase.
//
//   Ports
//     clk        clock
//     reset      synchronous, active-high reset
//     pf         barrier_field_if.slave
//                  in : clear, tick, run, cart_col
//                  out: field, crash, score (all registered)
//
//   Parameters
//     ROWS       playfield rows; row 0 = spawn row, row ROWS-1 = cart row
//     COLS       playfield columns; power of two in 2..16
//     SPEED_DIV  tick pulses per scroll step (>= 1)
//     SEED       LFSR reset value; must be nonzero
// ----------------------------------------------------------------------------
module barrier_field #(
    parameter int          ROWS      = 8,
    parameter int          COLS      = 8,
    parameter int          SPEED_DIV = 4,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic           clk,
    input  logic           reset,
    barrier_field_if.slave pf
);

    localparam int FIELD_W = ROWS * COLS;
    localparam int COL_W   = $clog2(COLS);
    // A divider of 1 still needs a one-bit counter to keep the compare legal.
    localparam int CNT_W   = (SPEED_DIV > 1) ? $clog2(SPEED_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPEED_DIV - 1);

    // ------------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------------

    // 16-bit Fibonacci LFSR, taps 16,14,13,11 (bit indices 15,13,12,10).
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Score counter saturates at 255 rather than wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // One-hot spawn row with the barrier in column col.
    function automatic logic [COLS-1:0] spawn_row(input logic [COL_W-1:0] col);
        logic [COLS-1:0] r;
        r      = '0;
        r[col] = 1'b1;
        return r;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [FIELD_W-1:0] field_q,    field_d;
    logic               crash_q,    crash_d;
    logic [7:0]         score_q,    score_d;
    logic [CNT_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic               spawn_ph_q, spawn_ph_d;
    logic [15:0]        lfsr_q,     lfsr_d;

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic [COLS-1:0]    last_row;
    logic [COLS-1:0]    new_row0;
    logic [FIELD_W-1:0] scrolled;
    logic               hit;
    logic               advance;
    logic               step;

    // Collision looks at the registered cart row only, so a barrier that is
    // just arriving this edge is caught one cycle later. cart_col is used
    // as-is; several set bits simply widen the collision footprint.
    assign last_row = field_q[(ROWS-1)*COLS +: COLS];
    assign hit      = |(last_row & pf.cart_col);

    // Ticks only count while the game runs and no crash is latched.
    assign advance  = pf.tick & pf.run & ~crash_q;
    assign step     = advance & (tick_cnt_q == CNT_LAST);

    // Rows move toward higher indices; the old cart row falls off the top
    // of the vector and the spawn row enters at the bottom bits.
    assign new_row0 = spawn_ph_q ? '0 : spawn_row(lfsr_q[COL_W-1:0]);
    assign scrolled = {field_q[(ROWS-1)*COLS-1:0], new_row0};

    always_comb begin
        field_d    = field_q;
        tick_cnt_d = tick_cnt_q;
        spawn_ph_d = spawn_ph_q;
        score_d    = score_q;
        // Crash is evaluated every cycle regardless of tick, run or clear.
        crash_d    = crash_q | hit;
        // The LFSR free-runs so spawn columns do not repeat game to game.
        lfsr_d     = lfsr_next(lfsr_q);

        if (pf.clear) begin
            // Wipe wins over a coincident step: no scroll, no score.
            field_d    = '0;
            tick_cnt_d = '0;
            spawn_ph_d = 1'b0;
        end else if (step) begin
            field_d    = scrolled;
            tick_cnt_d = '0;
            spawn_ph_d = ~spawn_ph_q;
            // A barrier leaving the cart row without a crash was dodged.
            if (last_row != '0) begin
                score_d = sat_inc(score_q);
            end
        end else if (advance) begin
            tick_cnt_d = tick_cnt_q + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            field_q    <= '0;
            crash_q    <= 1'b0;
            score_q    <= '0;
            tick_cnt_q <= '0;
            spawn_ph_q <= 1'b0;
            lfsr_q     <= SEED;
        end else begin
            field_q    <= field_d;
            crash_q    <= crash_d;
            score_q    <= score_d;
            tick_cnt_q <= tick_cnt_d;
            spawn_ph_q <= spawn_ph_d;
            lfsr_q     <= lfsr_d;
        end
    end

    assign pf.field = field_q;
    assign pf.crash = crash_q;
    assign pf.score = score_q;

endmodule

// File: tb/tb_barrier_field.sv
// ----------------------------------------------------------------------------
// tb_barrier_field
//   Directed bench for barrier_field. Stimulus pushes the expected outputs
//   into a scoreboard queue; a monitor on the falling edge pops and compares
//   them against the DUT.
// ----------------------------------------------------------------------------
module tb_barrier_field;
    localparam int          ROWS      = 8;
    localparam int          COLS      = 8;
    localparam int          SPEED_DIV = 4;
    localparam logic [15:0] SEED      = 16'hACE1;
    localparam int          FW        = ROWS * COLS;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    barrier_field_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

    barrier_field #(
        .ROWS(ROWS), .COLS(COLS), .SPEED_DIV(SPEED_DIV), .SEED(SEED)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .pf    (bus)
    );

    typedef struct {
        string         name;
        logic [FW-1:0] field;
        logic          crash;
        logic [7:0]    score;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference LFSR: taps 16,14,13,11, held at SEED during reset.
    logic [15:0] lfsr_m;
    always @(posedge clk) begin
        if (reset) lfsr_m <= SEED;
        else       lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end

    // Monitor: compares every queued expectation against the current outputs.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_tests++;
            if (bus.field !== e.field || bus.crash !== e.crash || bus.score !== e.score) begin
                n_fail++;
                $display("FAIL %s: got field=%h crash=%b score=%0d, want field=%h crash=%b score=%0d",
                         e.name, bus.field, bus.crash, bus.score, e.field, e.crash, e.score);
            end
        end
    end

    // Bench-side expectation state: spawn column per step since the last
    // wipe (-1 = empty row), expected map and expected score.
    int            sp[$];
    logic [FW-1:0] ef;
    logic [7:0]    score_e;
    bit            dodge;

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input string nm, input logic [FW-1:0] f,
                              input logic c, input logic [7:0] s);
        exp_t e;
        e.name  = nm;
        e.field = f;
        e.crash = c;
        e.score = s;
        sb.push_back(e);
    endtask

    // Row r holds whatever was spawned r steps ago.
    function automatic logic [FW-1:0] calc_field();
        logic [FW-1:0] f;
        f = '0;
        for (int r = 0; r < ROWS; r++) begin
            int idx;
            idx = sp.size() - 1 - r;
            if (idx >= 0 && sp[idx] >= 0) f[r*COLS + sp[idx]] = 1'b1;
        end
        return f;
    endfunction

    // Park the cart half a playfield away from any barrier in the cart row.
    task automatic set_cart();
        logic [COLS-1:0] r7;
        int c;
        if (!dodge) return;
        r7 = ef[(ROWS-1)*COLS +: COLS];
        c  = 0;
        for (int i = 0; i < COLS; i++) if (r7[i]) c = (i + COLS/2) % COLS;
        bus.cart_col = COLS'(1) << c;
    endtask

    // One full scroll period starting from tick_cnt=0 with tick and run high.
    task automatic do_step(input string nm);
        for (int i = 0; i < SPEED_DIV - 1; i++) begin
            edge1();
            expect_now({nm, "_wait"}, ef, 1'b0, score_e);
        end
        if (ef[(ROWS-1)*COLS +: COLS] != '0)
            score_e = (score_e == 8'hFF) ? 8'hFF : score_e + 8'd1;
        sp.push_back((sp.size() % 2 == 0) ? int'(lfsr_m[$clog2(COLS)-1:0]) : -1);
        edge1();
        ef = calc_field();
        expect_now(nm, ef, 1'b0, score_e);
        set_cart();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.clear    = 1'b0;
        bus.tick     = 1'b0;
        bus.run      = 1'b0;
        bus.cart_col = '0;
        ef      = '0;
        score_e = 8'd0;
        dodge   = 1'b1;

        // Reset state, then run=0 keeps the field frozen despite ticks.
        reset = 1'b1;
        edge1();
        edge1();
        expect_now("reset_state", '0, 1'b0, 8'd0);
        reset    = 1'b0;
        bus.tick = 1'b1;
        for (int i = 0; i < 20; i++) begin
            edge1();
            if (i == 9 || i == 19) expect_now("run0_frozen", '0, 1'b0, 8'd0);
        end

        // Fresh reset, then continuous ticks with run=1.
        reset = 1'b1;
        edge1();
        edge1();
        expect_now("reset_again", '0, 1'b0, 8'd0);
        reset   = 1'b0;
        bus.run = 1'b1;
        do_step("first_spawn");
        // SEED advanced three times is 16'h670F, so column 7.
        expect_now("first_spawn_hand", 64'h80, 1'b0, 8'd0);
        do_step("moved_row1");
        expect_now("moved_row1_hand", 64'h8000, 1'b0, 8'd0);
        do_step("step3");
        do_step("row3");

        // Clear mid-count: map wiped, counter restarts from zero.
        edge1();
        expect_now("pre_clear1", ef, 1'b0, score_e);
        edge1();
        expect_now("pre_clear2", ef, 1'b0, score_e);
        bus.clear = 1'b1;
        edge1();
        bus.clear = 1'b0;
        sp.delete();
        ef = '0;
        expect_now("clear_wipe", '0, 1'b0, 8'd0);
        do_step("after_clear");

        // Dodge barriers: eight rows leave the cart row by step 23.
        for (int k = 2; k <= 24; k++) begin
            do_step($sformatf("dodge%0d", k));
            if (k == 23) expect_now("dodge_score8", ef, 1'b0, 8'd8);
        end

        // Clear on the terminal tick while a barrier sits in the cart row.
        for (int i = 0; i < SPEED_DIV - 1; i++) begin
            edge1();
            expect_now("clr_step_wait", ef, 1'b0, score_e);
        end
        bus.clear = 1'b1;
        edge1();
        bus.clear = 1'b0;
        sp.delete();
        ef = '0;
        set_cart();
        expect_now("clear_vs_step", '0, 1'b0, 8'd8);
        do_step("post_clear_step");

        // Collision: cart placed on the barrier entering the cart row.
        for (int k = 2; k <= 7; k++) do_step($sformatf("approach%0d", k));
        dodge        = 1'b0;
        bus.cart_col = COLS'(1) << sp[0];
        do_step("enter_row7");
        edge1();
        expect_now("crash_set", ef, 1'b1, 8'd8);
        for (int i = 0; i < 30; i++) begin
            edge1();
            if (i % 10 == 9) expect_now("crash_frozen", ef, 1'b1, 8'd8);
        end
        bus.clear = 1'b1;
        edge1();
        bus.clear = 1'b0;
        ef = '0;
        expect_now("clear_in_crash", '0, 1'b1, 8'd8);

        // Reset mid-run beats a coincident clear and a wide cart.
        bus.clear    = 1'b1;
        bus.cart_col = '1;
        reset        = 1'b1;
        edge1();
        expect_now("reset_midrun", '0, 1'b0, 8'd0);
        reset        = 1'b0;
        bus.clear    = 1'b0;
        bus.cart_col = '0;
        sp.delete();
        ef      = '0;
        score_e = 8'd0;
        dodge   = 1'b1;
        do_step("reseed_spawn");
        expect_now("reseed_col_hand", 64'h80, 1'b0, 8'd0);

        // Long dodge run to reach and hold score saturation.
        for (int k = 2; k <= 520; k++) do_step($sformatf("sat%0d", k));
        expect_now("score_sat_hand", ef, 1'b0, 8'd255);

        @(negedge clk);
        #1;
        if (n_tests < 12) begin
            n_fail++;
            $display("FAIL coverage: only %0d checks executed", n_tests);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        if (n_fail == 0) $display("PASS");
        else             $display("FAIL");
        $finish;
    end
endmodule
